aib_link_init_seq: RTL and testbench

Master-side AIB link bring-up sequencer in the `i_aux_clk` domain. It produces the `c_ms_*` handshake flags consumed by the sideband shift register, which serializes them to the far die. It consumes the `c_sl_*` flags that the shift register de-serializes and resynchronizes. It walks oscillator transfer, TX DCD calibration, RX DLL lock, RX DCD calibration and RX alignment in order, with a glitch filter on every far-side flag and a per-state timeout.

---
 rtl/aib_link_init_seq_if.sv | 62 ++++++
 rtl/aib_link_init_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_aib_link_init_seq.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aib_link_init_seq_if.sv
// ---------------------------------------------------------------------------
// aib_link_init_seq_if
//
// Sideband handshake bundle between the master-side link bring-up sequencer
// and the sideband shift register that carries the flags to and from the
// far die.
//
// Signals:
//   c_sl_*  far-side flags, already de-serialized and in the i_aux_clk domain
//   c_ms_*  master-side flags handed to the shift register for serialization
//
// Modports:
//   master  the sequencer (consumes c_sl_*, produces c_ms_*)
//   slave   the shift register / far-side model (produces c_sl_*, consumes c_ms_*)
// ---------------------------------------------------------------------------
interface aib_link_init_seq_if;

  logic c_sl_osc_transfer_en;
  logic c_sl_tx_transfer_en;
  logic c_sl_rx_transfer_en;
  logic c_sl_rx_dll_lock;
  logic c_sl_tx_dcd_cal_done;

  logic c_ms_osc_transfer_en;
  logic c_ms_tx_dcd_cal_done;
  logic c_ms_tx_transfer_en;
  logic c_ms_rx_dll_lock;
  logic c_ms_rx_dcd_cal_done;
  logic c_ms_rx_transfer_en;
  logic c_ms_rx_align_done;

  modport master (
    input  c_sl_osc_transfer_en,
    input  c_sl_tx_transfer_en,
    input  c_sl_rx_transfer_en,
    input  c_sl_rx_dll_lock,
    input  c_sl_tx_dcd_cal_done,
    output c_ms_osc_transfer_en,
    output c_ms_tx_dcd_cal_done,
    output c_ms_tx_transfer_en,
    output c_ms_rx_dll_lock,
    output c_ms_rx_dcd_cal_done,
    output c_ms_rx_transfer_en,
    output c_ms_rx_align_done
  );

  modport slave (
    output c_sl_osc_transfer_en,
    output c_sl_tx_transfer_en,
    output c_sl_rx_transfer_en,
    output c_sl_rx_dll_lock,
    output c_sl_tx_dcd_cal_done,
    input  c_ms_osc_transfer_en,
    input  c_ms_tx_dcd_cal_done,
    input  c_ms_tx_transfer_en,
    input  c_ms_rx_dll_lock,
    input  c_ms_rx_dcd_cal_done,
    input  c_ms_rx_transfer_en,
    input  c_ms_rx_align_done
  );

endinterface

// File: rtl/aib_link_init_seq.sv
// ---------------------------------------------------------------------------
// aib_link_init_seq
//
// Master-side AIB link bring-up sequencer. Walks oscillator transfer, TX DCD
// calibration, RX DLL lock, RX DCD calibration and RX alignment in order,
// glitch-filters every far-side flag and bounds every wait state with a
// timeout. Everything runs in the i_aux_clk domain.
//
// Parameters:
//   STABLE_CYCLES   consecutive differing samples needed to flip a filtered flag (>=1)
//   TIMEOUT_CYCLES  maximum cycles spent in any wait state (>=2)
//
// Ports:
//   i_aux_clk            clock
//   i_rst_n              synchronous active-low reset
//   i_link_en            start bring-up when 1, abort to IDLE when 0
//   sb                   sideband flag bundle (c_sl_* in, c_ms_* out)
//   i_tx_dcd_cal_done    local TX DCD calibration complete
//   i_rx_dll_lock        local RX DLL locked
//   i_rx_dcd_cal_done    local RX DCD calibration complete
//   i_rx_align_done      local RX alignment complete
//   o_tx_dcd_cal_start   TX DCD calibration request
//   o_rx_dll_en          RX DLL enable
//   o_rx_dcd_cal_start   RX DCD calibration request
//   o_rx_align_start     RX alignment request
//   o_link_up            bring-up complete
//   o_error              timeout or loss of the far side
//   o_state              current state encoding (debug)
// ---------------------------------------------------------------------------
module aib_link_init_seq #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                       i_aux_clk,
  input  logic                       i_rst_n,
  input  logic                       i_link_en,
  aib_link_init_seq_if.master        sb,
  input  logic                       i_tx_dcd_cal_done,
  input  logic                       i_rx_dll_lock,
  input  logic                       i_rx_dcd_cal_done,
  input  logic                       i_rx_align_done,
  output logic                       o_tx_dcd_cal_start,
  output logic                       o_rx_dll_en,
  output logic                       o_rx_dcd_cal_start,
  output logic                       o_rx_align_start,
  output logic                       o_link_up,
  output logic                       o_error,
  output logic [3:0]                 o_state
);

  localparam int FW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_OSC      = 4'd1,
    ST_TX_CAL   = 4'd2,
    ST_TX_XFER  = 4'd3,
    ST_RX_DLL   = 4'd4,
    ST_RX_CAL   = 4'd5,
    ST_RX_ALIGN = 4'd6,
    ST_LINK_UP  = 4'd7,
    ST_ERROR    = 4'd8
  } state_e;

  typedef struct packed {
    logic msOscXfer;
    logic msTxDcdDone;
    logic msTxXfer;
    logic msRxDllLock;
    logic msRxDcdDone;
    logic msRxXfer;
    logic msRxAlignDone;
    logic txCalStart;
    logic rxDllEn;
    logic rxCalStart;
    logic alignStart;
    logic linkUp;
    logic error;
  } outs_t;

  // Far-side flag vector: [0] osc, [1] tx xfer, [2] rx xfer, [3] rx dll lock, [4] tx dcd done
  logic [4:0]    slRaw;
  logic [4:0]    slFilt_q, slFilt_d;
  logic [4:0]    slPrev_q;
  logic [FW-1:0] fltCnt_q [5];
  logic [FW-1:0] fltCnt_d [5];
  logic          dllPrev_q;

  state_e        state_q, state_d;
  logic [TW-1:0] tmoCnt_q, tmoCnt_d;
  outs_t         outs_q, outs_d;

  logic          waitState;
  logic          tmoHit;
  logic          exitOk;
  state_e        seqNext;
  logic          linkLost;

  assign slRaw = {sb.c_sl_tx_dcd_cal_done, sb.c_sl_rx_dll_lock, sb.c_sl_rx_transfer_en,
                  sb.c_sl_tx_transfer_en, sb.c_sl_osc_transfer_en};

  // Glitch filter: a flag only flips after STABLE_CYCLES consecutive samples
  // that disagree with the current filtered value; any agreeing sample
  // restarts the count.
  always_comb begin
    slFilt_d = slFilt_q;
    for (int i = 0; i < 5; i++) begin
      fltCnt_d[i] = '0;
      if (slRaw[i] != slFilt_q[i]) begin
        if (fltCnt_q[i] == FLT_LAST) begin
          slFilt_d[i] = slRaw[i];
        end else begin
          fltCnt_d[i] = fltCnt_q[i] + FW'(1);
        end
      end
    end
  end

  // Next-state logic. Exit conditions beat the timeout, and dropping
  // i_link_en beats everything except ERROR, which only releases to IDLE.
  always_comb begin
    state_d   = state_q;
    exitOk    = 1'b0;
    seqNext   = state_q;
    waitState = (state_q != ST_IDLE) && (state_q != ST_LINK_UP) && (state_q != ST_ERROR);
    tmoHit    = (tmoCnt_q == TMO_LAST);
    // Falling edges are taken on the registered filtered flags, so a far-side
    // drop costs one cycle on top of the filter latency.
    linkLost  = (|(slPrev_q & ~slFilt_q)) | (dllPrev_q & ~i_rx_dll_lock);

    case (state_q)
      ST_OSC: begin
        exitOk  = slFilt_q[0];
        seqNext = ST_TX_CAL;
      end
      ST_TX_CAL: begin
        exitOk  = i_tx_dcd_cal_done;
        seqNext = ST_TX_XFER;
      end
      ST_TX_XFER: begin
        exitOk  = slFilt_q[2] & slFilt_q[1];
        seqNext = ST_RX_DLL;
      end
      ST_RX_DLL: begin
        exitOk  = i_rx_dll_lock;
        seqNext = ST_RX_CAL;
      end
      ST_RX_CAL: begin
        exitOk  = i_rx_dcd_cal_done;
        seqNext = ST_RX_ALIGN;
      end
      ST_RX_ALIGN: begin
        exitOk  = i_rx_align_done & slFilt_q[3] & slFilt_q[4];
        seqNext = ST_LINK_UP;
      end
      default: begin
        exitOk  = 1'b0;
        seqNext = state_q;
      end
    endcase

    case (state_q)
      ST_IDLE:    state_d = ST_OSC;
      ST_LINK_UP: if (linkLost) state_d = ST_ERROR;
      ST_ERROR:   if (!i_link_en) state_d = ST_IDLE;
      default: begin
        if (exitOk) begin
          state_d = seqNext;
        end else if (tmoHit) begin
          state_d = ST_ERROR;
        end
      end
    endcase

    if (!i_link_en && (state_q != ST_ERROR)) begin
      state_d = ST_IDLE;
    end
  end

  // Timeout counter: restarts on every state change and saturates rather
  // than wrapping if a wait state were ever held past the limit.
  always_comb begin
    tmoCnt_d = tmoCnt_q;
    if (state_d != state_q) begin
      tmoCnt_d = '0;
    end else if (waitState && (tmoCnt_q != {TW{1'b1}})) begin
      tmoCnt_d = tmoCnt_q + TW'(1);
    end
  end

  // Moore output decode of the upcoming state, so outputs are registered
  // alongside the state. Handshake flags accumulate from their owning state
  // through LINK_UP; the one-shot requests are only live in their own state.
  always_comb begin
    outs_d = '0;
    if ((state_d != ST_IDLE) && (state_d != ST_ERROR)) begin
      outs_d.msOscXfer   = 1'b1;
      outs_d.msTxDcdDone = (state_d >= ST_TX_XFER);
      outs_d.msTxXfer    = (state_d >= ST_TX_XFER);
      outs_d.rxDllEn     = (state_d >= ST_RX_DLL);
      outs_d.msRxDllLock = (state_d >= ST_RX_CAL);
      outs_d.msRxDcdDone = (state_d >= ST_RX_ALIGN);
    end
    outs_d.txCalStart    = (state_d == ST_TX_CAL);
    outs_d.rxCalStart    = (state_d == ST_RX_CAL);
    outs_d.alignStart    = (state_d == ST_RX_ALIGN);
    outs_d.msRxAlignDone = (state_d == ST_LINK_UP);
    outs_d.msRxXfer      = (state_d == ST_LINK_UP);
    outs_d.linkUp        = (state_d == ST_LINK_UP);
    outs_d.error         = (state_d == ST_ERROR);
  end

  // State, filter, timeout and output registers with synchronous reset.
  always_ff @(posedge i_aux_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      tmoCnt_q  <= '0;
      outs_q    <= '0;
      slFilt_q  <= '0;
      slPrev_q  <= '0;
      dllPrev_q <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        fltCnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tmoCnt_q  <= tmoCnt_d;
      outs_q    <= outs_d;
      slFilt_q  <= slFilt_d;
      slPrev_q  <= slFilt_q;
      dllPrev_q <= i_rx_dll_lock;
      for (int i = 0; i < 5; i++) begin
        fltCnt_q[i] <= fltCnt_d[i];
      end
    end
  end

  assign sb.c_ms_osc_transfer_en = outs_q.msOscXfer;
  assign sb.c_ms_tx_dcd_cal_done = outs_q.msTxDcdDone;
  assign sb.c_ms_tx_transfer_en  = outs_q.msTxXfer;
  assign sb.c_ms_rx_dll_lock     = outs_q.msRxDllLock;
  assign sb.c_ms_rx_dcd_cal_done = outs_q.msRxDcdDone;
  assign sb.c_ms_rx_transfer_en  = outs_q.msRxXfer;
  assign sb.c_ms_rx_align_done   = outs_q.msRxAlignDone;
  assign o_tx_dcd_cal_start      = outs_q.txCalStart;
  assign o_rx_dll_en             = outs_q.rxDllEn;
  assign o_rx_dcd_cal_start      = outs_q.rxCalStart;
  assign o_rx_align_start        = outs_q.alignStart;
  assign o_link_up               = outs_q.linkUp;
  assign o_error                 = outs_q.error;
  assign o_state                 = state_q;

endmodule

// File: tb/tb_aib_link_init_seq.sv
// ---------------------------------------------------------------------------
// tb_aib_link_init_seq
//
// Self-checking bench for aib_link_init_seq (STABLE_CYCLES=4, TIMEOUT_CYCLES=16).
// Directed scenarios check fixed latencies; a random phase checks every cycle
// against a behavioural model of the bring-up rules.
// ---------------------------------------------------------------------------
module tb_aib_link_init_seq;

  localparam int STABLE = 4;
  localparam int TO     = 16;
  localparam int TMAX   = (1 << $clog2(TO)) - 1;

  logic       clk = 1'b0;
  logic       rstN;
  logic       linkEn;
  logic       txCalDone, rxDllLock, rxDcdDone, rxAlignDone;
  logic       txCalStart, rxDllEn, rxCalStart, alignStart, linkUp, err;
  logic [3:0] stateO;

  aib_link_init_seq_if sbIf ();

  aib_link_init_seq #(
    .STABLE_CYCLES (STABLE),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_aux_clk         (clk),
    .i_rst_n           (rstN),
    .i_link_en         (linkEn),
    .sb                (sbIf),
    .i_tx_dcd_cal_done (txCalDone),
    .i_rx_dll_lock     (rxDllLock),
    .i_rx_dcd_cal_done (rxDcdDone),
    .i_rx_align_done   (rxAlignDone),
    .o_tx_dcd_cal_start(txCalStart),
    .o_rx_dll_en       (rxDllEn),
    .o_rx_dcd_cal_start(rxCalStart),
    .o_rx_align_start  (alignStart),
    .o_link_up         (linkUp),
    .o_error           (err),
    .o_state           (stateO)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // {7 c_ms flags, txCalStart, rxDllEn, rxCalStart, alignStart, linkUp, error}
  logic [12:0] dutOut;
  assign dutOut = {sbIf.c_ms_osc_transfer_en, sbIf.c_ms_tx_dcd_cal_done, sbIf.c_ms_tx_transfer_en,
                   sbIf.c_ms_rx_dll_lock, sbIf.c_ms_rx_dcd_cal_done, sbIf.c_ms_rx_transfer_en,
                   sbIf.c_ms_rx_align_done, txCalStart, rxDllEn, rxCalStart, alignStart,
                   linkUp, err};

  logic [4:0] slVec;
  assign slVec = {sbIf.c_sl_tx_dcd_cal_done, sbIf.c_sl_rx_dll_lock, sbIf.c_sl_rx_transfer_en,
                  sbIf.c_sl_tx_transfer_en, sbIf.c_sl_osc_transfer_en};

  // Expected output vector for each bring-up stage
  function automatic logic [12:0] expOut(input int stage);
    case (stage)
      1:       return 13'b1000000_000000;
      2:       return 13'b1000000_100000;
      3:       return 13'b1110000_000000;
      4:       return 13'b1110000_010000;
      5:       return 13'b1111000_011000;
      6:       return 13'b1111100_010100;
      7:       return 13'b1111111_010010;
      8:       return 13'b0000000_000001;
      default: return 13'b0;
    endcase
  endfunction

  // Stage progression rules: 0 idle, 1..6 waiting stages, 7 link up, 8 error
  function automatic int modelNext(input int stage, input int tmo, input bit [4:0] f,
                                   input bit [4:0] fPrev, input bit dllPrev, input bit en,
                                   input bit txDone, input bit dll, input bit rxDone,
                                   input bit alignDone);
    bit exitOk;
    if (stage != 8 && !en) return 0;
    case (stage)
      0: return 1;
      7: return ((|(fPrev & ~f)) || (dllPrev && !dll)) ? 8 : 7;
      8: return en ? 8 : 0;
      default: begin
        case (stage)
          1:       exitOk = f[0];
          2:       exitOk = txDone;
          3:       exitOk = f[1] && f[2];
          4:       exitOk = dll;
          5:       exitOk = rxDone;
          default: exitOk = alignDone && f[3] && f[4];
        endcase
        if (exitOk) return stage + 1;
        if (tmo == TO - 1) return 8;
        return stage;
      end
    endcase
  endfunction

  int       mStage, mTmo;
  bit [4:0] mFilt, mFiltPrev;
  bit       mDllPrev;
  int       mRun [5];

  // Behavioural reference: flags flip after STABLE consecutive disagreeing
  // samples; the stage advances per modelNext; time-in-stage saturates.
  always @(posedge clk) begin
    if (!rstN) begin
      mStage    <= 0;
      mTmo      <= 0;
      mFilt     <= '0;
      mFiltPrev <= '0;
      mDllPrev  <= 1'b0;
      for (int i = 0; i < 5; i++) mRun[i] <= 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (slVec[i] == mFilt[i]) begin
          mRun[i] <= 0;
        end else if (mRun[i] + 1 >= STABLE) begin
          mFilt[i] <= slVec[i];
          mRun[i]  <= 0;
        end else begin
          mRun[i] <= mRun[i] + 1;
        end
      end
      mFiltPrev <= mFilt;
      mDllPrev  <= rxDllLock;
      mStage    <= modelNext(mStage, mTmo, mFilt, mFiltPrev, mDllPrev, linkEn,
                             txCalDone, rxDllLock, rxDcdDone, rxAlignDone);
      if (modelNext(mStage, mTmo, mFilt, mFiltPrev, mDllPrev, linkEn,
                    txCalDone, rxDllLock, rxDcdDone, rxAlignDone) != mStage) begin
        mTmo <= 0;
      end else if (mStage >= 1 && mStage <= 6 && mTmo < TMAX) begin
        mTmo <= mTmo + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    linkEn                    = 1'b0;
    txCalDone                 = 1'b0;
    rxDllLock                 = 1'b0;
    rxDcdDone                 = 1'b0;
    rxAlignDone               = 1'b0;
    sbIf.c_sl_osc_transfer_en = 1'b0;
    sbIf.c_sl_tx_transfer_en  = 1'b0;
    sbIf.c_sl_rx_transfer_en  = 1'b0;
    sbIf.c_sl_rx_dll_lock     = 1'b0;
    sbIf.c_sl_tx_dcd_cal_done = 1'b0;
  endtask

  task automatic doReset();
    rstN = 1'b0;
    clearInputs();
    tick();
    tick();
    rstN = 1'b1;
  endtask

  // Answer each request as it appears until the target stage is reached
  task automatic respond(input logic [3:0] st);
    case (st)
      4'd1: sbIf.c_sl_osc_transfer_en = 1'b1;
      4'd2: txCalDone = 1'b1;
      4'd3: begin
        sbIf.c_sl_tx_transfer_en = 1'b1;
        sbIf.c_sl_rx_transfer_en = 1'b1;
      end
      4'd4: rxDllLock = 1'b1;
      4'd5: rxDcdDone = 1'b1;
      4'd6: begin
        rxAlignDone               = 1'b1;
        sbIf.c_sl_rx_dll_lock     = 1'b1;
        sbIf.c_sl_tx_dcd_cal_done = 1'b1;
      end
      default: ;
    endcase
  endtask

  task automatic bringTo(input int target, output bit ok);
    ok     = 1'b0;
    linkEn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (stateO === 4'(target)) begin
        ok = 1'b1;
        return;
      end
      respond(stateO);
      tick();
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    clearInputs();
    linkEn = 1'b1;
    rxDllLock = 1'b1;
    sbIf.c_sl_osc_transfer_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      compared++;
      if (stateO !== 4'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_state: got %0d expected 0", stateO);
      end
      compared++;
      if (dutOut !== 13'd0) begin
        mismatched++;
        $display("[TB] FAIL reset_outputs: got %b expected 0", dutOut);
      end
    end
    clearInputs();
    rstN = 1'b1;
    tick();
    compared++;
    if (stateO !== 4'd0) begin
      mismatched++;
      $display("[TB] FAIL idle_hold: got %0d expected 0", stateO);
    end
  endtask

  task automatic test_nominal();
    int seq[$];
    int last = -1;
    doReset();
    linkEn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (int'(stateO) != last) seq.push_back(int'(stateO));
      last = int'(stateO);
      if (stateO === 4'd7) break;
      respond(stateO);
      tick();
    end
    compared++;
    if (seq.size() != 8) begin
      mismatched++;
      $display("[TB] FAIL nominal_len: got %0d states expected 8", seq.size());
    end
    for (int i = 0; i < 8 && i < seq.size(); i++) begin
      compared++;
      if (seq[i] != i) begin
        mismatched++;
        $display("[TB] FAIL nominal_step%0d: got %0d expected %0d", i, seq[i], i);
      end
    end
    compared++;
    if (linkUp !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL nominal_link_up: got %b expected 1", linkUp);
    end
    compared++;
    if (dutOut[12:6] !== 7'h7f) begin
      mismatched++;
      $display("[TB] FAIL nominal_ms_flags: got %b expected 1111111", dutOut[12:6]);
    end
  endtask

  task automatic test_glitch();
    bit stayed = 1'b1;
    int n = 0;
    doReset();
    linkEn = 1'b1;
    tick();
    compared++;
    if (stateO !== 4'd1) begin
      mismatched++;
      $display("[TB] FAIL glitch_osc_entry: got %0d expected 1", stateO);
    end
    sbIf.c_sl_osc_transfer_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (stateO !== 4'd1) stayed = 1'b0;
    end
    sbIf.c_sl_osc_transfer_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (stateO !== 4'd1) stayed = 1'b0;
    end
    compared++;
    if (!stayed) begin
      mismatched++;
      $display("[TB] FAIL glitch_ignored: got state %0d expected 1", stateO);
    end
    sbIf.c_sl_osc_transfer_en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (stateO !== 4'd1) begin
        n = k;
        break;
      end
    end
    compared++;
    if (n != STABLE + 1 || stateO !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL glitch_latency: got %0d cycles to state %0d expected 5 to 2", n, stateO);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int n = 0;
    doReset();
    bringTo(4, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL timeout_reach_rx_dll: got state %0d expected 4", stateO);
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (stateO !== 4'd4) begin
        n = k;
        break;
      end
    end
    compared++;
    if (n != TO || stateO !== 4'd8) begin
      mismatched++;
      $display("[TB] FAIL timeout_latency: got %0d cycles to state %0d expected 16 to 8", n, stateO);
    end
    compared++;
    if (err !== 1'b1 || dutOut[12:6] !== 7'd0) begin
      mismatched++;
      $display("[TB] FAIL timeout_outputs: got err=%b ms=%b expected err=1 ms=0", err, dutOut[12:6]);
    end
    tick();
    compared++;
    if (stateO !== 4'd8) begin
      mismatched++;
      $display("[TB] FAIL error_sticky: got %0d expected 8", stateO);
    end
    linkEn = 1'b0;
    tick();
    compared++;
    if (stateO !== 4'd0 || dutOut !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL error_release: got state %0d out %b expected 0/0", stateO, dutOut);
    end
  endtask

  task automatic test_timeout_tie();
    bit ok;
    doReset();
    bringTo(2, ok);
    for (int k = 0; k < TO - 1; k++) tick();
    compared++;
    if (!ok || stateO !== 4'd2) begin
      mismatched++;
      $display("[TB] FAIL tie_wait: got state %0d expected 2", stateO);
    end
    txCalDone = 1'b1;
    tick();
    compared++;
    if (stateO !== 4'd3) begin
      mismatched++;
      $display("[TB] FAIL tie_exit_wins: got %0d expected 3", stateO);
    end
  endtask

  task automatic test_link_loss();
    bit ok;
    int n = 0;
    doReset();
    bringTo(7, ok);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL loss_reach_link_up: got state %0d expected 7", stateO);
    end
    sbIf.c_sl_tx_transfer_en = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (stateO !== 4'd7) begin
        n = k;
        break;
      end
    end
    compared++;
    if (stateO !== 4'd8 || n != STABLE + 1) begin
      mismatched++;
      $display("[TB] FAIL loss_to_error: got state %0d after %0d cycles expected 8 after 5", stateO, n);
    end
    compared++;
    if (linkUp !== 1'b0 || err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL loss_outputs: got link_up=%b err=%b expected 0/1", linkUp, err);
    end
  endtask

  task automatic test_abort_and_reset();
    bit ok;
    doReset();
    bringTo(5, ok);
    linkEn = 1'b0;
    tick();
    compared++;
    if (!ok || stateO !== 4'd0 || dutOut !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL abort_rx_cal: got state %0d out %b expected 0/0", stateO, dutOut);
    end
    doReset();
    bringTo(7, ok);
    rstN = 1'b0;
    tick();
    compared++;
    if (!ok || stateO !== 4'd0 || dutOut !== 13'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_link_up: got state %0d out %b expected 0/0", stateO, dutOut);
    end
    rstN = 1'b1;
    clearInputs();
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 800; c++) begin
      rstN   = ($urandom_range(0, 149) != 0);
      linkEn = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 5) == 0) sbIf.c_sl_osc_transfer_en = ~sbIf.c_sl_osc_transfer_en;
      if ($urandom_range(0, 5) == 0) sbIf.c_sl_tx_transfer_en  = ~sbIf.c_sl_tx_transfer_en;
      if ($urandom_range(0, 5) == 0) sbIf.c_sl_rx_transfer_en  = ~sbIf.c_sl_rx_transfer_en;
      if ($urandom_range(0, 5) == 0) sbIf.c_sl_rx_dll_lock     = ~sbIf.c_sl_rx_dll_lock;
      if ($urandom_range(0, 5) == 0) sbIf.c_sl_tx_dcd_cal_done = ~sbIf.c_sl_tx_dcd_cal_done;
      if ($urandom_range(0, 9) == 0) rxDllLock = ~rxDllLock;
      txCalDone   = 1'($urandom_range(0, 1));
      rxDcdDone   = 1'($urandom_range(0, 1));
      rxAlignDone = 1'($urandom_range(0, 1));
      tick();
      compared++;
      if (stateO !== 4'(mStage)) begin
        mismatched++;
        $display("[TB] FAIL random_state cycle %0d: got %0d expected %0d", c, stateO, mStage);
      end
      compared++;
      if (dutOut !== expOut(mStage)) begin
        mismatched++;
        $display("[TB] FAIL random_outputs cycle %0d: got %b expected %b", c, dutOut, expOut(mStage));
      end
    end
  endtask

  initial begin
    rstN = 1'b0;
    clearInputs();
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_timeout_tie();
    test_link_loss();
    test_abort_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
